dir_validator: RTL and testbench
================================

# dir_validator

Direction scanner for the Othello move-validation path. It takes an origin cell, a signed step and the moving player. It walks the board memory one cell at a time along that step and reports whether the direction brackets at least one opponent disc with a disc of the mover's colour. It is the responder to the new-move controller's ld/enable/step handshake, and it reads the board RAM through its own read port.

## Interface
Parameters:
- ADDR_W, 7: board address width (cells 0..BOARD_CELLS-1).
- STEP_W, 5: signed step width; legal steps are -10, +10, -1, +1.
- MAX_RUN, 8: maximum opponent run length counted before forced failure.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- ld  in  1  load strobe; latches step_in, origin_in, player_in.
- enable  in  1  start strobe; honoured only in IDLE.
- step_in  in  STEP_W  signed two's-complement step.
- origin_in  in  ADDR_W  address of the cell being played.
- player_in  in  1  mover: 0 black, 1 white.
- mem_data_i  in  2  board RAM read data, valid one cycle after mem_rd_o.
- mem_addr_o  out  ADDR_W  board RAM read address.
- mem_rd_o  out  1  board RAM read strobe.
- s_done_o  out  1  one-cycle pulse marking scan completion.
- dir_status_o  out  1  1 if the direction is a capturing line.
- count_o  out  4  number of opponent discs in the run.

## Operation
- Cell encoding: 00 empty, 01 black, 10 white, 11 wall. Own = player_in ? 10 : 01. Opponent is the other colour.
- ld in any state except mid-scan latches the operands. ld during a scan is ignored. If ld and enable arrive in the same cycle, the scan uses the newly latched values.
- States:
  - IDLE: enable -> STEP. Clears count. Sets cur = origin.
  - STEP: nxt = cur + sign-extended step, computed at ADDR_W+2 bits signed. If nxt < 0 or nxt > BOARD_CELLS-1, set status 0 and go to DONE. Otherwise cur <= nxt and go to READ.
  - READ: mem_addr_o = cur, mem_rd_o = 1 -> CHECK.
  - CHECK: sample mem_data_i.
    - Opponent: count+1. If the new count exceeds MAX_RUN, status 0 and go to DONE; otherwise go to STEP.
    - Own: status = (count != 0), go to DONE.
    - Empty or wall: status 0, go to DONE.
  - DONE: s_done_o = 1 -> IDLE.
- dir_status_o and count_o are registered. They update on entry to DONE and hold until the next accepted enable, which clears both.
- enable outside IDLE is ignored; it is not queued.
- The block never writes memory.

## Timing
- Reset values: state IDLE, dir_status_o 0, count_o 0, s_done_o 0, mem_rd_o 0, mem_addr_o 0, latched operands 0.
- Reset low in any state takes effect at the next edge. An in-flight scan is aborted with no s_done_o pulse.
- Cycle numbering: the enable-sampling edge ends cycle 0.
- Cells examined k ≥ 1: s_done_o is high in cycle 3k+1.
  - Cell j is read with mem_rd_o high in cycle 3j-1.
  - Cell j's data is sampled in CHECK in cycle 3j.
- Out of range on step k+1: s_done_o is high in cycle 3k+2, with no read issued for that step.
- s_done_o is Moore (state == DONE) and lasts exactly one cycle. The block returns to IDLE the next cycle and can accept ld+enable in that same cycle.
- mem_rd_o is high only in READ. mem_addr_o holds its last value otherwise.

## Structure
- Shared package othello_pkg holds:
  - Cell encodings CELL_EMPTY, CELL_BLACK, CELL_WHITE, CELL_WALL.
  - BOARD_CELLS = 100 and ROW_STRIDE = 10.
  - ADDR_W.
  - Direction constants STEP_U = -10, STEP_D = +10, STEP_L = -1, STEP_R = +1, shared with the new-move controller.
- The state encoding is local to the module.
- Single flat module, no sub-module. The range check and next-address adder are inline combinational logic.

## Test plan
- Origin 44, step +1, black; RAM[45]=10, [46]=10, [47]=01 -> reads at 45, 46, 47; s_done_o in cycle 10; dir_status_o 1, count_o 2.
- Origin 44, step -10, black; RAM[34]=01 -> s_done_o in cycle 4; dir_status_o 0, count_o 0.
- Origin 44, step +1, white; RAM[45]=01, [46]=00 -> s_done_o in cycle 7; dir_status_o 0, count_o 1.
- Origin 5, step -10 -> no mem_rd_o; s_done_o in cycle 2; dir_status_o 0. Origin 95, step +10 -> same response.
- Four scans U, D, L, R driven back-to-back:
  - Each uses ld+enable in the cycle after the previous s_done_o.
  - Each uses the newly loaded step.
  - An enable pulse injected during READ is ignored.
- Reset low during the second CHECK of a 3-cell run:
  - Next cycle is IDLE with all outputs 0 and no s_done_o.
  - A fresh scan then completes normally.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared Othello board constants: cell encodings, board geometry and the
// direction steps used by the move-validation path.
package othello_pkg;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned BOARD_CELLS = 100;
  localparam int unsigned ROW_STRIDE  = 10;

  localparam int STEP_U = -int'(ROW_STRIDE);
  localparam int STEP_D = int'(ROW_STRIDE);
  localparam int STEP_L = -1;
  localparam int STEP_R = 1;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_BLACK = 2'b01,
    CELL_WHITE = 2'b10,
    CELL_WALL  = 2'b11
  } cell_e;

endpackage

// File: rtl/dir_validator.sv
// Walks the board RAM from an origin along one signed step and reports whether
// the direction brackets a run of opponent discs with a disc of the mover's colour.
module dir_validator
  import othello_pkg::*;
#(
  parameter int unsigned ADDR_W  = othello_pkg::ADDR_W,
  parameter int unsigned STEP_W  = 5,
  parameter int unsigned MAX_RUN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic              enable,
  input  logic [STEP_W-1:0] step_in,
  input  logic [ADDR_W-1:0] origin_in,
  input  logic              player_in,
  input  logic [1:0]        mem_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              s_done_o,
  output logic              dir_status_o,
  output logic [3:0]        count_o
);

  localparam int unsigned NXT_W = ADDR_W + 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_READ,
    S_CHECK,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [ADDR_W-1:0]  origin_q, origin_d;
  logic               player_q, player_d;
  logic [ADDR_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               status_q, status_d;
  logic               done_q, done_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic [NXT_W-1:0]   nxt;
  logic               in_range;
  logic [CNT_W-1:0]   new_cnt;
  logic [1:0]         own_cell;
  logic [1:0]         opp_cell;

  // Next address at two extra bits so both underflow and overflow are visible.
  assign nxt      = {2'b00, cur_q} + {{(NXT_W-STEP_W){step_q[STEP_W-1]}}, step_q};
  assign in_range = !nxt[NXT_W-1] && (nxt <= NXT_W'(BOARD_CELLS - 1));
  assign new_cnt  = cnt_q + CNT_W'(1);
  assign own_cell = player_q ? CELL_WHITE : CELL_BLACK;
  assign opp_cell = player_q ? CELL_BLACK : CELL_WHITE;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    origin_d = origin_q;
    player_d = player_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    status_d = status_q;
    done_d   = 1'b0;
    rd_d     = 1'b0;
    addr_d   = addr_q;

    // Operands are only reloadable while no scan is in flight.
    if (ld && (state_q == S_IDLE || state_q == S_DONE)) begin
      step_d   = step_in;
      origin_d = origin_in;
      player_d = player_in;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_STEP;
          cnt_d    = '0;
          count_d  = '0;
          status_d = 1'b0;
          cur_d    = ld ? origin_in : origin_q;
        end
      end
      S_STEP: begin
        if (!in_range) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = 1'b0;
          count_d  = cnt_q;
        end else begin
          state_d = S_READ;
          cur_d   = nxt[ADDR_W-1:0];
          addr_d  = nxt[ADDR_W-1:0];
          rd_d    = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mem_data_i == opp_cell) begin
          cnt_d = new_cnt;
          if (new_cnt > CNT_W'(MAX_RUN)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = 1'b0;
            count_d  = new_cnt;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = (mem_data_i == own_cell) && (cnt_q != '0);
          count_d  = cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      origin_q <= '0;
      player_q <= 1'b0;
      cur_q    <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      status_q <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      origin_q <= origin_d;
      player_q <= player_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      status_q <= status_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_rd_o     = rd_q;
  assign s_done_o     = done_q;
  assign dir_status_o = status_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_dir_validator.sv
// Bench for dir_validator: directed scenarios plus randomized boards, checked
// against a direct walk of the board model.
module tb_dir_validator;
  import othello_pkg::*;

  localparam int unsigned STEP_W  = 5;
  localparam int unsigned MAX_RUN = 8;
  localparam int unsigned NCELL   = 100;

  logic              clock;
  logic              reset;
  logic              ld;
  logic              enable;
  logic [STEP_W-1:0] step_in;
  logic [6:0]        origin_in;
  logic              player_in;
  logic [1:0]        mem_data;
  logic [6:0]        mem_addr_o;
  logic              mem_rd_o;
  logic              s_done_o;
  logic              dir_status_o;
  logic [3:0]        count_o;

  logic [1:0] ram [0:NCELL-1];
  int exp_reads[$];
  int tests;
  int fails;

  dir_validator #(.ADDR_W(7), .STEP_W(STEP_W), .MAX_RUN(MAX_RUN)) dut (
    .clock        (clock),
    .reset        (reset),
    .ld           (ld),
    .enable       (enable),
    .step_in      (step_in),
    .origin_in    (origin_in),
    .player_in    (player_in),
    .mem_data_i   (mem_data),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .s_done_o     (s_done_o),
    .dir_status_o (dir_status_o),
    .count_o      (count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Board RAM with one-cycle read latency.
  always @(posedge clock) begin
    if (mem_rd_o && (mem_addr_o < 7'(NCELL))) mem_data <= ram[mem_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < int'(NCELL); i++) ram[i] = CELL_EMPTY;
  endtask

  // Reference: walk the board from the origin following the capture rules.
  task automatic model(input int origin, input int step, input bit player,
                       output int st, output int cn, output int dc);
    int cur, nxt, k, cnt;
    logic [1:0] own, opp, c;
    own = player ? CELL_WHITE : CELL_BLACK;
    opp = player ? CELL_BLACK : CELL_WHITE;
    exp_reads.delete();
    cur = origin; k = 0; cnt = 0; st = 0; cn = 0; dc = 0;
    for (int guard = 0; guard < 20; guard++) begin
      nxt = cur + step;
      if (nxt < 0 || nxt > int'(NCELL) - 1) begin
        st = 0; cn = cnt; dc = 3 * k + 2;
        break;
      end
      cur = nxt; k++;
      exp_reads.push_back(nxt);
      c = ram[nxt];
      if (c == opp) begin
        cnt++;
        if (cnt > int'(MAX_RUN)) begin
          st = 0; cn = cnt; dc = 3 * k + 1;
          break;
        end
      end else begin
        st = ((c == own) && (cnt != 0)) ? 1 : 0;
        cn = cnt; dc = 3 * k + 1;
        break;
      end
    end
  endtask

  // Starts a scan in the current cycle and checks it through to one cycle past done.
  task automatic scan(input int origin, input int step, input bit player,
                      input bit use_ld, input bit inject);
    int st, cn, dc, got_done, rd_cnt, c;
    model(origin, step, player, st, cn, dc);
    if (use_ld) begin
      ld        = 1'b1;
      step_in   = STEP_W'(step);
      origin_in = 7'(origin);
      player_in = player;
    end
    enable   = 1'b1;
    got_done = -1;
    rd_cnt   = 0;
    c        = 0;
    while (got_done < 0 && c < 40) begin
      @(posedge clock); #1;
      c++;
      ld     = 1'b0;
      enable = 1'b0;
      if (inject && c == 2) begin
        enable    = 1'b1;
        ld        = 1'b1;
        step_in   = STEP_W'(STEP_D);
        origin_in = 7'd0;
        player_in = ~player;
      end
      if (c == 1) begin
        chk("clear_status", 32'(dir_status_o), 0);
        chk("clear_count", 32'(count_o), 0);
      end
      if (mem_rd_o) begin
        chk("rd_addr", 32'(mem_addr_o),
            (rd_cnt < exp_reads.size()) ? 32'(exp_reads[rd_cnt]) : 32'hFFFF_FFFF);
        chk("rd_cycle", 32'(c), 32'(3 * (rd_cnt + 1) - 1));
        rd_cnt++;
      end
      if (s_done_o) got_done = c;
    end
    ld     = 1'b0;
    enable = 1'b0;
    chk("done_cycle", 32'(got_done), 32'(dc));
    chk("rd_total", 32'(rd_cnt), 32'(exp_reads.size()));
    chk("dir_status", 32'(dir_status_o), 32'(st));
    chk("count", 32'(count_o), 32'(cn));
    @(posedge clock); #1;
    chk("done_width", 32'(s_done_o), 0);
    chk("status_hold", 32'(dir_status_o), 32'(st));
  endtask

  initial begin
    int steps [4];
    steps[0] = STEP_U; steps[1] = STEP_D; steps[2] = STEP_L; steps[3] = STEP_R;
    tests = 0; fails = 0;
    reset = 1'b0; ld = 1'b0; enable = 1'b0;
    step_in = '0; origin_in = '0; player_in = 1'b0;
    clear_ram();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd", 32'(mem_rd_o), 0);
    chk("rst_addr", 32'(mem_addr_o), 0);
    chk("rst_done", 32'(s_done_o), 0);
    chk("rst_status", 32'(dir_status_o), 0);
    chk("rst_count", 32'(count_o), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Reset operands are zero: origin 0, step 0 reads cell 0 once.
    scan(0, 0, 1'b0, 1'b0, 1'b0);

    // Capture of two white discs by black.
    ram[45] = CELL_WHITE; ram[46] = CELL_WHITE; ram[47] = CELL_BLACK;
    scan(44, STEP_R, 1'b0, 1'b1, 1'b0);

    clear_ram();
    ram[34] = CELL_BLACK;
    scan(44, STEP_U, 1'b0, 1'b1, 1'b0);

    clear_ram();
    ram[45] = CELL_BLACK; ram[46] = CELL_EMPTY;
    scan(44, STEP_R, 1'b1, 1'b1, 1'b0);

    // Off-board on the first step.
    scan(5, STEP_U, 1'b0, 1'b1, 1'b0);
    scan(95, STEP_D, 1'b0, 1'b1, 1'b0);

    // Back-to-back U, D, L, R with an ignored ld/enable during READ of one.
    clear_ram();
    ram[34] = CELL_WHITE; ram[24] = CELL_BLACK;
    ram[54] = CELL_WHITE; ram[64] = CELL_WHITE; ram[74] = CELL_BLACK;
    ram[43] = CELL_BLACK;
    ram[45] = CELL_WHITE; ram[46] = CELL_WALL;
    scan(44, STEP_U, 1'b0, 1'b1, 1'b0);
    scan(44, STEP_D, 1'b0, 1'b1, 1'b1);
    scan(44, STEP_L, 1'b0, 1'b1, 1'b0);
    scan(44, STEP_R, 1'b0, 1'b1, 1'b0);
    // Enable alone reuses the last loaded operands, not the ones offered mid-scan.
    scan(44, STEP_D, 1'b0, 1'b1, 1'b1);
    scan(44, STEP_D, 1'b0, 1'b0, 1'b0);

    // Reset during the second CHECK of a three-disc run.
    clear_ram();
    ram[45] = CELL_WHITE; ram[46] = CELL_WHITE; ram[47] = CELL_WHITE; ram[48] = CELL_BLACK;
    ld = 1'b1; enable = 1'b1;
    step_in = STEP_W'(STEP_R); origin_in = 7'd44; player_in = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock); #1;
      ld = 1'b0; enable = 1'b0;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("abort_done", 32'(s_done_o), 0);
    chk("abort_rd", 32'(mem_rd_o), 0);
    chk("abort_addr", 32'(mem_addr_o), 0);
    chk("abort_status", 32'(dir_status_o), 0);
    chk("abort_count", 32'(count_o), 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      chk("abort_quiet", 32'({s_done_o, mem_rd_o}), 0);
    end
    scan(44, STEP_R, 1'b0, 1'b1, 1'b0);

    // Randomized boards, origins, directions and movers.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'(NCELL); i++) ram[i] = 2'($urandom_range(0, 3));
      scan(int'($urandom_range(0, NCELL - 1)), steps[$urandom_range(0, 3)],
           1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
